// File: rtl/wei_ram_reader_if.sv
// Weight SRAM read port plus PE-facing word stream.
// master = reader side, slave = wrapper/PE side.
interface wei_ram_reader_if #(
  parameter int SRAM_DEPTH_BIT = 6,
  parameter int SRAM_WIDTH     = 28
);
  logic                      ram_read_en;
  logic [SRAM_DEPTH_BIT-1:0] ram_addr_r;
  logic [SRAM_WIDTH-1:0]     ram_data;
  logic [SRAM_WIDTH-1:0]     out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;

  modport master (
    output ram_read_en,
    output ram_addr_r,
    input  ram_data,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport slave (
    input  ram_read_en,
    input  ram_addr_r,
    output ram_data,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );
endinterface

// File: rtl/wei_ram_reader.sv
// Burst reader for the weight SRAM wrapper.
// Streams words to the PE array through a 2-entry skid FIFO.
module wei_ram_reader #(
  parameter int SRAM_DEPTH_BIT = 6,
  parameter int SRAM_WIDTH     = 28
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [SRAM_DEPTH_BIT-1:0] base_addr,
  input  logic [SRAM_DEPTH_BIT:0]   len,
  input  logic                      wr_block,
  output logic                      busy,
  output logic                      done,
  wei_ram_reader_if.master          bus
);
  localparam int AW = SRAM_DEPTH_BIT;
  localparam int DW = SRAM_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [AW:0]   len_q;
  logic [AW:0]   issued;
  logic [AW-1:0] rd_ptr;
  logic          inflight;
  logic          inflight_last;
  logic [DW-1:0] fifo_data [2];
  logic          fifo_last [2];
  logic          wr_sel;
  logic          rd_sel;
  logic [1:0]    occ;
  logic          done_q;

  logic          read;
  logic          pop;
  logic          credit;
  logic          head_last;
  logic          done_d;
  logic          load;

  assign pop       = bus.out_valid & bus.out_ready;
  assign head_last = fifo_last[rd_sel];
  assign load      = (state_q == IDLE) & start & (len != '0);

  // Words already owed to the FIFO must fit after this cycle's pop.
  assign credit = ({1'b0, occ} + {2'b0, inflight})
                < (3'd2 + {2'b0, pop});

  always_comb begin
    state_d = state_q;
    read    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && len == '0) done_d = 1'b1;
        if (load) state_d = READ;
      end
      READ: begin
        read = (issued < len_q) & ~wr_block & credit;
        if (issued == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      len_q         <= '0;
      issued        <= '0;
      rd_ptr        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      inflight      <= read;
      inflight_last <= read & (issued == len_q - 1'b1);
      if (load) begin
        len_q  <= len;
        rd_ptr <= base_addr;
        issued <= '0;
      end else if (read) begin
        rd_ptr <= rd_ptr + 1'b1;
        issued <= issued + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      occ    <= '0;
    end else begin
      if (inflight) begin
        fifo_data[wr_sel] <= bus.ram_data;
        fifo_last[wr_sel] <= inflight_last;
        wr_sel            <= ~wr_sel;
      end
      if (pop) rd_sel <= ~rd_sel;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

  assign bus.ram_read_en = read;
  assign bus.ram_addr_r  = read ? rd_ptr : '0;
  assign bus.out_valid   = (occ != '0);
  assign bus.out_data    = fifo_data[rd_sel];
  assign bus.out_last    = bus.out_valid & head_last;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
endmodule

// File: tb/tb_wei_ram_reader.sv
// Randomized self-checking bench for wei_ram_reader.
// Reference is a queue of expected words per burst.
module tb_wei_ram_reader;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  len;
  logic        wr_block;
  logic        busy;
  logic        done;
  logic [27:0] mem [64];
  int          vectors;
  int          miscompares;

  wei_ram_reader_if #(.SRAM_DEPTH_BIT(6), .SRAM_WIDTH(28)) bus ();

  wei_ram_reader #(.SRAM_DEPTH_BIT(6), .SRAM_WIDTH(28)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .wr_block  (wr_block),
    .busy      (busy),
    .done      (done),
    .bus       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle SRAM; garbage when no read so stale captures show up
  always @(posedge clk)
    bus.ram_data <= bus.ram_read_en ? mem[bus.ram_addr_r] : 28'($urandom);

  task automatic run_burst(input int base, input int n, input bit rnd_ready,
                           input int wb_at, input int start2_at,
                           output int first_rd, output int first_vld,
                           output int done_at);
    logic [27:0] expq[$];
    logic [27:0] prev_data;
    bit prev_stall;
    bit fin;
    bit rd, hs, exp_done, exp_busy, exp_last;
    int issued, popped, last_hs, k;
    logic [5:0] exp_addr;
    prev_stall = 0; fin = 0; prev_data = '0;
    issued = 0; popped = 0; last_hs = -10; k = 0;
    first_rd = -1; first_vld = -1; done_at = -1;
    for (int i = 0; i < n; i++) expq.push_back(mem[(base + i) % 64]);
    while (1) begin
      @(negedge clk);
      start = (k == 0) || (k == start2_at);
      base_addr = (k == 0) ? 6'(base) : 6'($urandom);
      len = (k == 0) ? 7'(n) : 7'($urandom_range(0, 64));
      wr_block = (wb_at >= 0 && k >= wb_at && k < wb_at + 3);
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      rd = bus.ram_read_en;
      hs = bus.out_valid & bus.out_ready;
      if (rd && first_rd < 0) first_rd = k;
      if (bus.out_valid && first_vld < 0) first_vld = k;
      if (done && done_at < 0) done_at = k;
      vectors++;
      if (!rd && bus.ram_addr_r !== 6'd0) begin
        miscompares++;
        $display("FAIL addr_idle k=%0d got=%0d want=0", k, bus.ram_addr_r);
      end
      if (rd) begin
        exp_addr = 6'((base + issued) % 64);
        vectors++;
        if (issued >= n || wr_block || bus.ram_addr_r !== exp_addr) begin
          miscompares++;
          $display("FAIL read k=%0d addr=%0d want=%0d issued=%0d wr_block=%0b",
                   k, bus.ram_addr_r, exp_addr, issued, wr_block);
        end
        issued++;
      end
      if (prev_stall) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
          miscompares++;
          $display("FAIL stable k=%0d valid=%0b data=%h want=%h",
                   k, bus.out_valid, bus.out_data, prev_data);
        end
      end
      if (hs) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL extra_word k=%0d got=%h want=none", k, bus.out_data);
        end else begin
          exp_last = (expq.size() == 1);
          if (bus.out_data !== expq[0] || bus.out_last !== exp_last) begin
            miscompares++;
            $display("FAIL word k=%0d got=%h/%0b want=%h/%0b",
                     k, bus.out_data, bus.out_last, expq[0], exp_last);
          end
          void'(expq.pop_front());
        end
        popped++;
      end
      vectors++;
      if (issued - popped > 2) begin
        miscompares++;
        $display("FAIL credit k=%0d outstanding=%0d want<=2", k, issued - popped);
      end
      exp_done = (n == 0 && k == 1) || (last_hs == k - 1);
      exp_busy = (n != 0) && (k >= 1) && !fin;
      vectors++;
      if (done !== exp_done || busy !== exp_busy) begin
        miscompares++;
        $display("FAIL status k=%0d done=%0b busy=%0b want=%0b/%0b",
                 k, done, busy, exp_done, exp_busy);
      end
      if (hs && expq.size() == 0 && n != 0 && !fin) begin
        fin = 1; last_hs = k;
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data = bus.out_data;
      if (n == 0 && k >= 2) break;
      if (fin && k >= last_hs + 2) break;
      if (k >= 400) begin
        miscompares++;
        $display("FAIL timeout got=%0d_left want=0", expq.size());
        break;
      end
      k++;
    end
    @(negedge clk);
    start = 0; wr_block = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; wr_block = 0; bus.out_ready = 0;
    base_addr = '0; len = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.ram_read_en, bus.ram_addr_r, bus.out_valid, bus.out_data,
         bus.out_last, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got=%b want=0", {bus.ram_read_en,
               bus.ram_addr_r, bus.out_valid, bus.out_data, bus.out_last, busy, done});
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int fr, fv, da;
    for (int i = 0; i < 64; i++) mem[i] = 28'(i + 'h100);
    run_burst(5, 4, 0, -1, -1, fr, fv, da);
    vectors++;
    if (fr != 1 || fv != 3 || da != 7) begin
      miscompares++;
      $display("FAIL basic_timing rd/vld/done=%0d/%0d/%0d want=1/3/7", fr, fv, da);
    end
  endtask

  task automatic test_wrap();
    int fr, fv, da;
    for (int i = 0; i < 64; i++) mem[i] = 28'($urandom);
    run_burst(62, 4, 0, -1, -1, fr, fv, da);
    run_burst(60, 9, 1, -1, -1, fr, fv, da);
  endtask

  task automatic test_backpressure();
    int fr, fv, da;
    for (int r = 0; r < 6; r++)
      run_burst($urandom_range(0, 63), 8, 1, -1, -1, fr, fv, da);
  endtask

  task automatic test_wr_block();
    int fr, fv, da;
    run_burst(10, 10, 0, 3, -1, fr, fv, da);
    run_burst(40, 12, 1, 2, -1, fr, fv, da);
  endtask

  task automatic test_len0_and_start_busy();
    int fr, fv, da;
    run_burst(7, 0, 0, -1, -1, fr, fv, da);
    vectors++;
    if (fr != -1 || da != 1) begin
      miscompares++;
      $display("FAIL len0 first_rd=%0d done_at=%0d want=-1/1", fr, da);
    end
    run_burst(20, 6, 0, -1, 3, fr, fv, da);
    run_burst(33, 5, 1, -1, 4, fr, fv, da);
  endtask

  task automatic test_reset_mid();
    int fr, fv, da, hs_cnt, k;
    hs_cnt = 0; k = 0;
    @(negedge clk);
    start = 1; base_addr = 6'd50; len = 7'd12; bus.out_ready = 1;
    while (hs_cnt < 2 && k < 50) begin
      @(negedge clk);
      start = 0;
      #1;
      if (bus.out_valid && bus.out_ready) hs_cnt++;
      k++;
    end
    @(negedge clk);
    rst_n = 0;
    #1;
    vectors++;
    if ({bus.ram_read_en, bus.ram_addr_r, bus.out_valid, bus.out_data,
         bus.out_last, busy, done} !== '0 || hs_cnt != 2) begin
      miscompares++;
      $display("FAIL reset_mid got=%b hs=%0d want=0/2", {bus.ram_read_en,
               bus.ram_addr_r, bus.out_valid, bus.out_data, bus.out_last,
               busy, done}, hs_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_burst($urandom_range(0, 63), 6, 1, -1, -1, fr, fv, da);
  endtask

  task automatic test_random();
    int fr, fv, da;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = 28'($urandom);
      run_burst($urandom_range(0, 63), $urandom_range(1, 64), 1,
                $urandom_range(1, 10), -1, fr, fv, da);
    end
    run_burst(0, 64, 0, -1, -1, fr, fv, da);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    bus.ram_data = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_wr_block();
    test_len0_and_start_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wei_ram_reader.md
Name: wei_ram_reader

Overview:
Read-side client of the weight SRAM wrapper. It accepts a burst request (base address, word count) and issues read_en/addr_r to the wrapper. It captures the 1-cycle-latency read data into a 2-entry skid FIFO and streams the words to the PE array over a valid/ready interface with a last flag. A credit check on reads keeps words from being lost under backpressure. Reads are held off while the loader is writing, because write_en takes the wrapper's address mux.

Parameters:
SRAM_DEPTH_BIT, 6, wrapper address width; depth = 2**SRAM_DEPTH_BIT
SRAM_WIDTH, 28, weight word width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  burst request pulse; sampled only in IDLE
base_addr  input  SRAM_DEPTH_BIT  first word address; sampled with start
len  input  SRAM_DEPTH_BIT+1  word count, 0..2**SRAM_DEPTH_BIT; sampled with start
wr_block  input  1  loader write in progress; no read issued in a cycle where high
ram_read_en  output  1  to wrapper read_en
ram_addr_r  output  SRAM_DEPTH_BIT  to wrapper addr_r
ram_data  input  SRAM_WIDTH  from wrapper data_out; valid the cycle after ram_read_en
out_data  output  SRAM_WIDTH  weight word to PE
out_valid  output  1  out_data valid
out_ready  input  1  PE accepts
out_last  output  1  marks final word of burst; qualified by out_valid
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset state:
  - All outputs 0: ram_read_en, ram_addr_r, out_valid, out_data, out_last, busy, done.
  - FIFO empty, in-flight flag clear, FSM = IDLE.
- Output timing:
  - ram_read_en and ram_addr_r are combinational from state, counters, wr_block and out_ready.
  - ram_addr_r = 0 whenever ram_read_en = 0.
- FSM states: IDLE, READ, DRAIN.
  - IDLE, start=1, len!=0: latch base_addr/len. Set rd_ptr=base_addr, issued=0, accepted=0, busy=1. Go to READ.
  - IDLE, start=1, len=0: no reads. done=1 next cycle. busy stays 0. Stay IDLE.
  - READ: on issued==len, go to DRAIN.
  - DRAIN: on the handshake of the last word, go to IDLE. busy=0 and done=1 in the following cycle.
  - start while not in IDLE is ignored.
- Read issue, in READ only:
  - pop = out_valid & out_ready.
  - ram_read_en = (issued<len) & ~wr_block & (occ + inflight - pop < 2).
  - occ = FIFO occupancy (0..2). inflight = registered copy of ram_read_en.
  - Each issue: ram_addr_r = rd_ptr, then rd_ptr += 1 modulo 2**SRAM_DEPTH_BIT (wraps 63->0 at default), issued += 1.
- Capture:
  - When inflight=1, ram_data is pushed into the FIFO at that clock edge.
  - ram_data is ignored in any cycle where inflight=0. The wrapper holds stale data then.
- Output:
  - The FIFO head drives out_data and out_valid.
  - out_last=1 on the head entry whose index == len-1. A tag bit is stored per entry.
  - out_data is stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - start in cycle 0 -> first ram_read_en in cycle 1 -> data pushed at end of cycle 2 -> out_valid in cycle 3.
  - Throughput is 1 word/cycle with out_ready and wr_block held low.
- Backpressure:
  - The credit rule guarantees the FIFO never overflows.
  - Push and pop in the same cycle are both legal with occ=2.
- Reset mid-burst: all state clears immediately. In-flight read data is discarded and no done is produced.
- wr_block only pauses issue. Already-issued reads still complete and are captured.

Test Plan:
- Basic burst: base=5, len=4, mem[i]=i+0x100, out_ready=1 -> reads at addr 5,6,7,8 in cycles 1-4; outputs 0x105..0x108 in cycles 3-6, out_last on 0x108; done in cycle 7; busy 1..6.
- Wrap: base=62, len=4 -> ram_addr_r sequence 62,63,0,1; data order preserved; last on addr-1 word.
- Backpressure: len=8, out_ready toggles 1,0,0,1,... randomly -> no loss or duplication; occ never exceeds 2; out_data stable while stalled; 8 handshakes then done.
- wr_block: assert for 3 cycles mid-burst -> ram_read_en=0 during those cycles; burst resumes and contents are correct.
- len=0 and start while busy: len=0 -> done next cycle with no ram_read_en; start during a burst -> ignored, current burst unaffected.
- Reset mid-burst: rst_n low after 2 words -> all outputs 0 immediately; a new burst after release is correct and produces no stale word.
